// File: rtl/pmem_line_bridge_pkg.sv
// Shared types and constants for the line-to-word physical memory bridge.
package pmem_line_bridge_pkg;

  localparam int LINE_WIDTH      = 128;
  localparam int WORD_WIDTH      = 16;
  localparam int LINE_ADDR_WIDTH = 12;
  localparam int PMEM_BEATS      = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_BITS       = $clog2(PMEM_BEATS);
  localparam int TIMEOUT_CYCLES  = 255;

  typedef logic [LINE_WIDTH-1:0]      lc3b_line;
  typedef logic [LINE_ADDR_WIDTH-1:0] lc3b_line_addr;
  typedef logic [WORD_WIDTH-1:0]      lc3b_word;
  typedef logic [BEAT_BITS-1:0]       beat_idx_t;

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} pmem_bridge_state_t;

  // Byte address of one beat: words are 2 bytes, so bit 0 is always clear.
  function automatic lc3b_word beat_byte_addr(lc3b_line_addr line_addr, beat_idx_t beat);
    return {line_addr, beat, 1'b0};
  endfunction

endpackage

// File: rtl/pmem_line_bridge_if.sv
// Cache line port plus downstream word port. slave = the bridge, master = cache and memory side.
interface pmem_line_bridge_if;
  import pmem_line_bridge_pkg::*;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_line_addr pmem_address;
  lc3b_line      pmem_wdata;
  lc3b_line      pmem_rdata;
  logic          pmem_resp;
  logic          pmem_error;

  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_error,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_error,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/pmem_line_buffer.sv
// 128-bit line register: whole-line load for writes, per-word fill for reads, word mux out.
module pmem_line_buffer
  import pmem_line_bridge_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_line,
  input  lc3b_line  line_in,
  input  logic      word_we,
  input  beat_idx_t word_sel,
  input  lc3b_word  word_in,
  output lc3b_word  word_out,
  output lc3b_line  line_out
);

  lc3b_line line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_line) begin
      line_d = line_in;
    end else if (word_we) begin
      line_d[WORD_WIDTH*word_sel +: WORD_WIDTH] = word_in;
    end
  end

  // NOTE: this wide register is reset on purpose so the assembled read line is zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) line_q <= '0;
    else       line_q <= line_d;
  end

  assign word_out = line_q[WORD_WIDTH*word_sel +: WORD_WIDTH];
  assign line_out = line_q;

endmodule

// File: rtl/pmem_line_bridge.sv
// Splits 128-bit cache line reads/writes into eight 16-bit word transactions.
// Optional per-beat timeout abort is enabled with `define PMEM_BRIDGE_TIMEOUT_EN.
module pmem_line_bridge
  import pmem_line_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pmem_line_bridge_if.slave bus
);

  pmem_bridge_state_t state_q, state_d;
  beat_idx_t          beat_q, beat_d;
  lc3b_line_addr      addr_q, addr_d;

  logic     load_line;
  logic     word_we;
  logic     beat_done;
  logic     mem_read;
  logic     mem_write;
  logic     pmem_resp;
  lc3b_word word_out;
  lc3b_line line_out;

`ifdef PMEM_BRIDGE_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;
`endif

  pmem_line_buffer u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .load_line(load_line),
    .line_in  (bus.pmem_wdata),
    .word_we  (word_we),
    .word_sel (beat_q),
    .word_in  (bus.mem_rdata),
    .word_out (word_out),
    .line_out (line_out)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    load_line = 1'b0;
    word_we   = 1'b0;
    beat_done = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Read wins a tie; the cache re-presents the write afterwards.
        if (bus.pmem_read) begin
          addr_d  = bus.pmem_address;
          beat_d  = '0;
          state_d = RD_BEAT;
        end else if (bus.pmem_write) begin
          addr_d    = bus.pmem_address;
          beat_d    = '0;
          load_line = 1'b1;
          state_d   = WR_BEAT;
        end
      end
      RD_BEAT: begin
        mem_read  = 1'b1;
        word_we   = bus.mem_resp;
        beat_done = bus.mem_resp;
      end
      WR_BEAT: begin
        mem_write = 1'b1;
        beat_done = bus.mem_resp;
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (beat_done) begin
      if (beat_q == beat_idx_t'(PMEM_BEATS-1)) state_d = DONE;
      else                                      beat_d  = beat_q + 1'b1;
    end
  end

`ifdef PMEM_BRIDGE_TIMEOUT_EN
  // Timer counts waiting cycles of the current beat; TIMEOUT_CYCLES of silence aborts the line.
  always_comb begin
    timer_d = timer_q;
    err_d   = err_q;
    if (state_q == RD_BEAT || state_q == WR_BEAT) begin
      if (beat_done) begin
        timer_d = '0;
      end else if (timer_q == 8'(TIMEOUT_CYCLES-1)) begin
        timer_d = '0;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (state_q == IDLE) begin
      timer_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`endif

  // Abort overrides the beat FSM; the partially filled line is returned as-is.
  pmem_bridge_state_t state_nxt;
`ifdef PMEM_BRIDGE_TIMEOUT_EN
  assign state_nxt = (err_d && !err_q) ? DONE : state_d;
`else
  assign state_nxt = state_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_nxt;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_address = beat_byte_addr(addr_q, beat_q);
  assign bus.mem_wdata   = word_out;
  assign bus.pmem_rdata  = line_out;
  assign bus.pmem_resp   = pmem_resp;
`ifdef PMEM_BRIDGE_TIMEOUT_EN
  assign bus.pmem_error  = pmem_resp & err_q;
`else
  assign bus.pmem_error  = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_bridge.sv
// Scoreboard bench for pmem_line_bridge: directed line transfers against a word memory model.
module tb_pmem_line_bridge;
  import pmem_line_bridge_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmem_line_bridge_if bus ();

  pmem_line_bridge dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word memory model: fixed wait states per beat, optional withheld address.
  int       wait_cfg = 0;
  int       mem_mode = 0;
  int       wait_cnt = 0;
  bit       hold_en  = 1'b0;
  lc3b_word hold_addr = '0;

  function automatic lc3b_word mem_word(int mode, lc3b_word a);
    if (mode == 0) return 16'(a[3:1]) * 16'h1111;
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if ((bus.mem_read || bus.mem_write) && !bus.mem_resp) wait_cnt <= wait_cnt + 1;
    else                                                  wait_cnt <= 0;
  end

  always_comb begin
    bus.mem_resp  = (bus.mem_read || bus.mem_write) && (wait_cnt >= wait_cfg) &&
                    !(hold_en && bus.mem_address == hold_addr);
    bus.mem_rdata = mem_word(mem_mode, bus.mem_address);
  end

  // Scoreboard queues.
  typedef struct {
    bit       wr;
    lc3b_word addr;
    lc3b_word data;
  } beat_t;

  typedef struct {
    bit       chk_rdata;
    lc3b_line rdata;
    bit       err;
    int       cyc;
  } line_t;

  beat_t exp_beats[$];
  line_t exp_lines[$];
  beat_t mb;
  line_t ml;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_read || bus.mem_write) begin
        check("beat_expected", 128'(exp_beats.size() != 0), 128'(1));
        if (exp_beats.size() != 0) begin
          mb = exp_beats[0];
          check("beat_mem_write", 128'(bus.mem_write), 128'(mb.wr));
          check("beat_mem_read", 128'(bus.mem_read), 128'(!mb.wr));
          check("beat_addr", 128'(bus.mem_address), 128'(mb.addr));
          if (bus.mem_resp) begin
            if (mb.wr) check("beat_wdata", 128'(bus.mem_wdata), 128'(mb.data));
            void'(exp_beats.pop_front());
          end
        end
      end
      if (bus.pmem_resp) begin
        check("line_expected", 128'(exp_lines.size() != 0), 128'(1));
        if (exp_lines.size() != 0) begin
          ml = exp_lines.pop_front();
          check("line_resp_cycle", 128'(cyc), 128'(ml.cyc));
          check("line_error", 128'(bus.pmem_error), 128'(ml.err));
          if (ml.chk_rdata) check("line_rdata", bus.pmem_rdata, ml.rdata);
        end
      end else begin
        check("error_without_resp", 128'(bus.pmem_error), 128'(0));
      end
    end
  end

  task automatic push_beat(bit wr, lc3b_word a, lc3b_word d);
    beat_t b;
    b.wr = wr; b.addr = a; b.data = d;
    exp_beats.push_back(b);
  endtask

  task automatic push_read_beats(lc3b_line_addr a, int n);
    for (int i = 0; i < n; i++) push_beat(1'b0, {a, 3'(i), 1'b0}, 16'h0);
  endtask

  // Issue one line request and hold it until the cycle after pmem_resp.
  task automatic run_line(bit rd, bit wr, lc3b_line_addr a, lc3b_line wd,
                          bit chk, lc3b_line exp_rd, bit exp_err, int lat);
    line_t l;
    bit    got;
    @(negedge clk);
    l.chk_rdata = chk; l.rdata = exp_rd; l.err = exp_err; l.cyc = cyc + lat;
    exp_lines.push_back(l);
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = a;
    bus.pmem_wdata   = wd;
    got = 1'b0;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      got = bus.pmem_resp;
    end
    check("pmem_resp_seen", 128'(got), 128'(1));
    @(negedge clk);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_mem_read"}, 128'(bus.mem_read), 128'(0));
    check({tag, "_mem_write"}, 128'(bus.mem_write), 128'(0));
    check({tag, "_pmem_resp"}, 128'(bus.pmem_resp), 128'(0));
    check({tag, "_pmem_error"}, 128'(bus.pmem_error), 128'(0));
    check({tag, "_mem_address"}, 128'(bus.mem_address), 128'(0));
    check({tag, "_mem_wdata"}, 128'(bus.mem_wdata), 128'(0));
    check({tag, "_pmem_rdata"}, bus.pmem_rdata, 128'(0));
  endtask

  localparam lc3b_line RAMP_LINE = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  initial begin
    lc3b_line exp_line;
    lc3b_line wline;

    reset            = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Zero-wait read, words = beat * 0x1111.
    wait_cfg = 0; mem_mode = 0;
    push_read_beats(12'h0A3, 8);
    run_line(1'b1, 1'b0, 12'h0A3, '0, 1'b1, RAMP_LINE, 1'b0, 9);

    // Zero-wait write: beat i carries bytes {2i+1, 2i}.
    for (int i = 0; i < 8; i++) push_beat(1'b1, 16'h0040 + 16'(2*i), {8'(2*i+1), 8'(2*i)});
    run_line(1'b0, 1'b1, 12'h004, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 1'b0, '0, 1'b0, 9);

    // Write with one wait state per beat.
    wait_cfg = 1;
    wline = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    for (int i = 0; i < 8; i++) push_beat(1'b1, {12'h800, 3'(i), 1'b0}, wline[16*i +: 16]);
    run_line(1'b0, 1'b1, 12'h800, wline, 1'b0, '0, 1'b0, 17);

    // Read with three wait states per beat; address must hold while waiting.
    wait_cfg = 3; mem_mode = 1;
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[16*i +: 16] = {12'h5C1, 3'(i), 1'b0} ^ 16'hA5A5;
    push_read_beats(12'h5C1, 8);
    run_line(1'b1, 1'b0, 12'h5C1, '0, 1'b1, exp_line, 1'b0, 33);

    // Read and write together at the top line address: read only.
    wait_cfg = 0; mem_mode = 0;
    push_read_beats(12'hFFF, 8);
    run_line(1'b1, 1'b1, 12'hFFF, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b1, RAMP_LINE, 1'b0, 9);

    // Reset during beat 4 of a read, then a clean read.
    push_read_beats(12'h321, 5);
    @(negedge clk);
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 12'h321;
    repeat (5) @(negedge clk);
    check("rst_beat4_addr", 128'(bus.mem_address), 128'(16'h3218));
    #1;
    reset         = 1'b1;
    bus.pmem_read = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    check("beats_after_reset", 128'(exp_beats.size()), 128'(0));
    reset = 1'b0;
    push_read_beats(12'h321, 8);
    run_line(1'b1, 1'b0, 12'h321, '0, 1'b1, RAMP_LINE, 1'b0, 9);

`ifdef PMEM_BRIDGE_TIMEOUT_EN
    // Beat 2 never answered: abort 255 cycles after that beat starts.
    hold_en   = 1'b1;
    hold_addr = {12'h0B0, 3'd2, 1'b0};
    push_read_beats(12'h0B0, 3);
    run_line(1'b1, 1'b0, 12'h0B0, '0, 1'b0, '0, 1'b1, 258);
    check("timeout_beat_left", 128'(exp_beats.size()), 128'(1));
    exp_beats.delete();
    hold_en = 1'b0;
    push_read_beats(12'h0B0, 8);
    run_line(1'b1, 1'b0, 12'h0B0, '0, 1'b1, RAMP_LINE, 1'b0, 9);
`endif

    repeat (3) @(negedge clk);
    check("beats_drained", 128'(exp_beats.size()), 128'(0));
    check("lines_drained", 128'(exp_lines.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
